// File: rtl/cpu_pkg.sv
// Shared opcode, addressing-mode, field-position and state definitions for the sequencer.
// Pure declarations; no timing or flow control.
package cpu_pkg;

  localparam int INSTR_W = 49;
  localparam int OPC_HI  = 48;
  localparam int OPC_LO  = 44;
  localparam int MODE_HI = 43;
  localparam int MODE_LO = 42;
  localparam int LIT_HI  = 31;
  localparam int LIT_LO  = 0;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LD   = 5'h01;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_XOR  = 5'h07;
  localparam logic [4:0] OP_NOT  = 5'h08;
  localparam logic [4:0] OP_SL   = 5'h09;
  localparam logic [4:0] OP_SR   = 5'h0A;
  localparam logic [4:0] OP_BZ   = 5'h10;
  localparam logic [4:0] OP_BNZ  = 5'h11;
  localparam logic [4:0] OP_BRA  = 5'h12;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam logic [1:0] MODE_IMM = 2'd0;
  localparam logic [1:0] MODE_DIR = 2'd1;
  localparam logic [1:0] MODE_IND = 2'd2;
  localparam logic [1:0] MODE_REG = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BZ) || (op == OP_BNZ) || (op == OP_BRA);
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: reset, branch-target load, or +1 (wrapping); one-cycle update.
// No flow control; load takes priority over increment.
module pc_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= target;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control: 4 cycles per instruction, 3 per branch.
// run is sampled in IDLE and at the end of WRITEBACK only; write enables pulse once in WRITEBACK.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OP  = 5'h1F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [48:0]     rom_data,
  output logic [48:0]     ir,
  input  logic            dec_register_load,
  input  logic            dec_ram_wr,
  input  logic            alu_zero,
  output logic            register_load,
  output logic            ram_wr,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            halted
);

  state_t      state_q;
  logic [48:0] ir_q;
  logic        z_q;
  logic [4:0]  opcode;
  logic        branch_taken;
  logic        pc_inc;
  logic        pc_load;

  assign opcode = ir_q[OPC_HI:OPC_LO];

  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_BRA:  branch_taken = 1'b1;
      OP_BZ:   branch_taken = z_q;
      OP_BNZ:  branch_taken = !z_q;
      default: branch_taken = 1'b0;
    endcase
  end

  assign pc_inc  = (state_q == S_DECODE);
  assign pc_load = (state_q == S_EXECUTE) && branch_taken;

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (ir_q[PC_W-1:0]),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    if (run) state_q <= S_FETCH;
        S_FETCH:   state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= rom_data;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_branch(opcode))     state_q <= S_FETCH;
          else if (opcode == HALT_OP) state_q <= S_HALT;
          else                       state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (dec_register_load) z_q <= alu_zero;
          state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT:    state_q <= S_HALT;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst so a reset landing in WRITEBACK suppresses the write that cycle.
  assign register_load = (state_q == S_WRITEBACK) && !rst && dec_register_load;
  assign ram_wr        = (state_q == S_WRITEBACK) && !rst && dec_ram_wr;

  assign rom_addr = pc;
  assign ir       = ir_q;
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);

endmodule
